// File: rtl/image_mgr_pkg.sv
// Shared types and constants for the ioctl image manager.
// IMAGE_MGR_CRC16_EN selects the CRC-16 fingerprint constants instead of the masked-sum ones.
package image_mgr_pkg;

  typedef enum logic [1:0] {
    TUTOR   = 2'd0,
    PYUTA   = 2'd1,
    PYUTAJR = 2'd2,
    UNKNOWN = 2'd3
  } variant_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } erase_state_t;

`ifdef IMAGE_MGR_CRC16_EN
  localparam bit USE_CRC = 1'b1;
`else
  localparam bit USE_CRC = 1'b0;
`endif

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam logic [15:0] SUM_TUTOR   = 16'h2E8E;
  localparam logic [15:0] SUM_PYUTA   = 16'h23D7;
  localparam logic [15:0] SUM_PYUTAJR = 16'h1127;

  localparam logic [15:0] CRC_TUTOR   = 16'h6A1C;
  localparam logic [15:0] CRC_PYUTA   = 16'hB3F2;
  localparam logic [15:0] CRC_PYUTAJR = 16'h59D0;

  localparam logic [15:0] HASH_INIT   = USE_CRC ? CRC_INIT : 16'h0000;
  localparam logic [15:0] KEY_TUTOR   = USE_CRC ? CRC_TUTOR : SUM_TUTOR;
  localparam logic [15:0] KEY_PYUTA   = USE_CRC ? CRC_PYUTA : SUM_PYUTA;
  localparam logic [15:0] KEY_PYUTAJR = USE_CRC ? CRC_PYUTAJR : SUM_PYUTAJR;

  // MSB-first CRC-16/CCITT update of one byte.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

  function automatic variant_t decode_variant(input logic [15:0] h);
    if (h == KEY_TUTOR)        return TUTOR;
    else if (h == KEY_PYUTA)   return PYUTA;
    else if (h == KEY_PYUTAJR) return PYUTAJR;
    else                       return UNKNOWN;
  endfunction

endpackage

// File: rtl/image_hash.sv
// Running system-ROM fingerprint: masked additive sum, or CRC-16/CCITT when
// IMAGE_MGR_CRC16_EN is defined.
module image_hash
  import image_mgr_pkg::*;
#(
  parameter logic [7:0] HASH_MASK = 8'h01
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        clear,
  input  logic        strobe,
  input  logic [7:0]  data,
  output logic [15:0] hash
);

  logic [15:0] base;
  logic [15:0] next_hash;

  // A strobe in the same cycle as a clear folds into the freshly cleared value.
  assign base = clear ? HASH_INIT : hash;

`ifdef IMAGE_MGR_CRC16_EN
  assign next_hash = crc16_byte(base, data);
`else
  assign next_hash = base + {8'h00, data & HASH_MASK};
`endif

  always_ff @(posedge clk_sys) begin
    if (RESET)       hash <= '0;
    else if (strobe) hash <= next_hash;
    else if (clear)  hash <= HASH_INIT;
  end

endmodule

// File: rtl/ioctl_image_manager.sv
// Routes hps_io ioctl downloads into program RAM port B, fingerprints the system ROM,
// erases the cartridge region on eject and drives the console reset hold. Option: IMAGE_MGR_CRC16_EN.
module ioctl_image_manager
  import image_mgr_pkg::*;
#(
  parameter int                ADDR_W     = 17,
  parameter logic [7:0]        CART_IDX   = 8'd2,
  parameter logic [ADDR_W-1:0] CART_BASE  = 17'h10000,
  parameter int unsigned       CART_BYTES = 32'h10000,
  parameter bit                SWAP_BYTES = 1'b1,
  parameter logic [7:0]        HASH_MASK  = 8'h01,
  parameter int                RESET_HOLD = 255
) (
  input  logic              clk_sys,
  input  logic              RESET,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              eject,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic [15:0]       rom_hash,
  output logic              rom_valid,
  output logic [1:0]        system_type,
  output logic [ADDR_W-1:0] cart_size,
  output logic              erasing,
  output logic              core_reset
);

  localparam int                HOLD_W      = $clog2(RESET_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(RESET_HOLD);
  localparam logic [ADDR_W-1:0] CART_LAST   = CART_BASE + ADDR_W'(CART_BYTES - 1);
  localparam logic [ADDR_W-1:0] SWAP_MASK   = {{(ADDR_W-1){1'b0}}, SWAP_BYTES};

  erase_state_t      state;
  variant_t          variant;
  logic              dl_prev, eject_prev, rom_load;
  logic              dl_rise, dl_fall, eject_rise;
  logic              rom_sel, cart_ok;
  logic [ADDR_W-1:0] rom_addr, cart_addr, cart_end, size_base, erase_ptr;
  logic [HOLD_W-1:0] hold_cnt;

  assign dl_rise    = ioctl_download & ~dl_prev;
  assign dl_fall    = ~ioctl_download & dl_prev;
  assign eject_rise = eject & ~eject_prev;
  assign rom_sel    = (ioctl_index[7:1] == 7'd0);
  assign cart_ok    = (ioctl_index == CART_IDX) && (32'(ioctl_addr) < CART_BYTES);
  assign rom_addr   = ioctl_addr[ADDR_W-1:0] ^ SWAP_MASK;
  assign cart_addr  = (CART_BASE + ioctl_addr[ADDR_W-1:0]) ^ SWAP_MASK;
  assign cart_end   = ioctl_addr[ADDR_W-1:0] + ADDR_W'(1);
  assign size_base  = dl_rise ? '0 : cart_size;

  assign erasing     = (state != ST_IDLE);
  assign system_type = variant;
  assign rom_valid   = (variant != UNKNOWN);
  assign core_reset  = (hold_cnt != '0) || ioctl_download || erasing || !rom_valid;

  image_hash #(.HASH_MASK(HASH_MASK)) u_hash (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .clear   (dl_rise && rom_sel),
    .strobe  (ioctl_download && ioctl_wr && rom_sel),
    .data    (ioctl_dout),
    .hash    (rom_hash)
  );

  // An active download always owns the RAM port and kills any erase in flight.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      dl_prev    <= 1'b0;
      eject_prev <= 1'b0;
      rom_load   <= 1'b0;
      state      <= ST_IDLE;
      erase_ptr  <= '0;
      variant    <= UNKNOWN;
      cart_size  <= '0;
      hold_cnt   <= HOLD_RELOAD;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
    end else begin
      dl_prev    <= ioctl_download;
      eject_prev <= eject;
      ram_we     <= 1'b0;

      if (dl_rise) rom_load <= rom_sel;
      if (dl_fall && rom_load) variant <= decode_variant(rom_hash);

      if (ioctl_download || erasing) hold_cnt <= HOLD_RELOAD;
      else if (hold_cnt != '0)       hold_cnt <= hold_cnt - HOLD_W'(1);

      if (ioctl_download) begin
        state <= ST_IDLE;
        if (ioctl_wr && rom_sel) begin
          ram_we   <= 1'b1;
          ram_addr <= rom_addr;
          ram_din  <= ioctl_dout;
        end else if (ioctl_wr && cart_ok) begin
          ram_we    <= 1'b1;
          ram_addr  <= cart_addr;
          ram_din   <= ioctl_dout;
          cart_size <= (cart_end > size_base) ? cart_end : size_base;
        end else if (dl_rise && ioctl_index == CART_IDX) begin
          cart_size <= '0;
        end
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (eject_rise) begin
              state     <= ST_WRITE;
              erase_ptr <= CART_BASE;
              cart_size <= '0;
              ram_we    <= 1'b1;
              ram_addr  <= CART_BASE;
              ram_din   <= 8'h00;
            end
          end
          ST_WRITE: state <= ST_GAP;
          ST_GAP: begin
            if (erase_ptr == CART_LAST) begin
              state <= ST_IDLE;
            end else begin
              state     <= ST_WRITE;
              erase_ptr <= erase_ptr + ADDR_W'(1);
              ram_we    <= 1'b1;
              ram_addr  <= erase_ptr + ADDR_W'(1);
              ram_din   <= 8'h00;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ioctl_image_manager.sv
// Self-checking bench for ioctl_image_manager (default build, 16-byte cartridge region).
module tb_ioctl_image_manager;

  localparam int         ADDR_W     = 17;
  localparam logic [7:0] CART_IDX   = 8'd2;
  localparam int         CART_BASE  = 'h10000;
  localparam int         CART_BYTES = 16;
  localparam int         RESET_HOLD = 255;

  logic              clk_sys = 1'b0;
  logic              RESET, ioctl_download, ioctl_wr, eject;
  logic [7:0]        ioctl_index, ioctl_dout;
  logic [24:0]       ioctl_addr;
  logic              ram_we, rom_valid, erasing, core_reset;
  logic [ADDR_W-1:0] ram_addr, cart_size;
  logic [7:0]        ram_din;
  logic [15:0]       rom_hash;
  logic [1:0]        system_type;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] RESET_VEC = {1'b0, 17'd0, 8'd0, 16'd0, 1'b0, 2'd3, 17'd0, 1'b0, 1'b1};
  logic [63:0] out_vec;
  assign out_vec = {ram_we, ram_addr, ram_din, rom_hash, rom_valid, system_type, cart_size, erasing, core_reset};

  always #5 clk_sys = ~clk_sys;

  ioctl_image_manager #(.CART_BYTES(CART_BYTES)) dut (
    .clk_sys(clk_sys), .RESET(RESET), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .eject(eject),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .rom_hash(rom_hash),
    .rom_valid(rom_valid), .system_type(system_type), .cart_size(cart_size),
    .erasing(erasing), .core_reset(core_reset)
  );

  function automatic int model_type(input int h);
    case (h)
      'h2E8E:  return 0;
      'h23D7:  return 1;
      'h1127:  return 2;
      default: return 3;
    endcase
  endfunction

  task automatic test_reset();
    RESET = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; eject = 1'b0;
    ioctl_index = 8'd0; ioctl_addr = '0; ioctl_dout = 8'd0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if (out_vec !== RESET_VEC) begin errors++; $display("[TB] FAIL reset_outputs: got %h want %h", out_vec, RESET_VEC); end
    RESET = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_rom_small();
    logic [7:0] d [4];
    int model = 0;
    d = '{8'h01, 8'h00, 8'h01, 8'h01};
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = d[i];
      model = (model + (d[i] & 8'h01)) % 65536;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 17'(i ^ 1) || ram_din !== d[i]) begin
        errors++; $display("[TB] FAIL rom_small_write[%0d]: got we=%0b addr=%h din=%h want we=1 addr=%h din=%h", i, ram_we, ram_addr, ram_din, i ^ 1, d[i]);
      end
    end
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (rom_hash !== 16'(model)) begin errors++; $display("[TB] FAIL rom_small_hash: got %h want %h", rom_hash, model); end
    checks++;
    if (system_type !== 2'(model_type(model)) || core_reset !== 1'b1) begin
      errors++; $display("[TB] FAIL rom_small_type: got type=%0d core_reset=%0b want type=%0d core_reset=1", system_type, core_reset, model_type(model));
    end
  endtask

  task automatic test_rom_variant();
    int sum = 0;
    int n = 0;
    int fall_at = 0;
    logic [7:0] b;
    ioctl_index = 8'($urandom_range(0, 1)); ioctl_download = 1'b1;
    @(negedge clk_sys);
    while (sum != 'h2E8E && n < 60000) begin
      b = 8'($urandom);
      ioctl_wr = 1'b1; ioctl_addr = 25'(n); ioctl_dout = b;
      sum = sum + (b & 8'h01);
      n++;
      @(negedge clk_sys);
    end
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (rom_hash !== 16'(sum)) begin errors++; $display("[TB] FAIL variant_hash: got %h want %h", rom_hash, sum); end
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (system_type !== 2'(model_type(sum)) || rom_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL variant_decode: got type=%0d valid=%0b want type=%0d valid=1", system_type, rom_valid, model_type(sum));
    end
    if (core_reset === 1'b0) fall_at = 1;
    for (int k = 2; k <= 400 && fall_at == 0; k++) begin
      @(negedge clk_sys);
      if (core_reset === 1'b0) fall_at = k;
    end
    checks++;
    if (fall_at != RESET_HOLD) begin errors++; $display("[TB] FAIL variant_reset_release: got %0d cycles want %0d", fall_at, RESET_HOLD); end
  endtask

  task automatic test_cart(input int nwr);
    int model_size = 0;
    int a;
    logic [7:0] b;
    ioctl_index = CART_IDX; ioctl_download = 1'b1;
    for (int i = 0; i < nwr; i++) begin
      @(negedge clk_sys);
      a = (i < 2) ? i : (i == nwr - 1) ? CART_BYTES : $urandom_range(0, CART_BYTES + 7);
      b = 8'($urandom);
      ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_dout = b;
      eject = (i == 3);
      @(negedge clk_sys);
      ioctl_wr = 1'b0; eject = 1'b0;
      checks++;
      if (a < CART_BYTES) begin
        if (a + 1 > model_size) model_size = a + 1;
        if (ram_we !== 1'b1 || ram_addr !== 17'((CART_BASE + a) ^ 1) || ram_din !== b) begin
          errors++; $display("[TB] FAIL cart_write[%0d]: got we=%0b addr=%h din=%h want we=1 addr=%h din=%h", i, ram_we, ram_addr, ram_din, (CART_BASE + a) ^ 1, b);
        end
      end else if (ram_we !== 1'b0) begin
        errors++; $display("[TB] FAIL cart_drop[%0d]: got we=%0b want 0 (addr %0d)", i, ram_we, a);
      end
      checks++;
      if (erasing !== 1'b0) begin errors++; $display("[TB] FAIL cart_no_erase[%0d]: got %0b want 0", i, erasing); end
    end
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (cart_size !== 17'(model_size)) begin errors++; $display("[TB] FAIL cart_size: got %h want %h", cart_size, model_size); end
    checks++;
    if (system_type !== 2'd0) begin errors++; $display("[TB] FAIL cart_keeps_type: got %0d want 0", system_type); end
  endtask

  task automatic test_erase();
    int wr_cnt = 0;
    int er_cnt = 0;
    int fall_at = 0;
    bit seen = 1'b0;
    bit done = 1'b0;
    eject = 1'b1;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk_sys);
      if (c == 1) eject = 1'b0;
      if (erasing === 1'b1) begin
        er_cnt++; seen = 1'b1;
      end else if (seen) begin
        done = 1'b1;
      end
      if (!done && ram_we === 1'b1) begin
        checks++;
        if (ram_addr !== 17'(CART_BASE + wr_cnt) || ram_din !== 8'h00) begin
          errors++; $display("[TB] FAIL erase_write[%0d]: got addr=%h din=%h want addr=%h din=00", wr_cnt, ram_addr, ram_din, CART_BASE + wr_cnt);
        end
        wr_cnt++;
      end
      if (c == 10) begin
        checks++;
        if (core_reset !== 1'b1 || cart_size !== '0) begin
          errors++; $display("[TB] FAIL erase_midway: got core_reset=%0b cart_size=%h want 1 and 0", core_reset, cart_size);
        end
      end
    end
    checks++;
    if (wr_cnt != CART_BYTES) begin errors++; $display("[TB] FAIL erase_count: got %0d want %0d", wr_cnt, CART_BYTES); end
    checks++;
    if (er_cnt != 2 * CART_BYTES) begin errors++; $display("[TB] FAIL erase_duration: got %0d want %0d", er_cnt, 2 * CART_BYTES); end
    for (int k = 1; k <= 400 && fall_at == 0; k++) begin
      @(negedge clk_sys);
      if (core_reset === 1'b0) fall_at = k;
    end
    checks++;
    if (fall_at != RESET_HOLD) begin errors++; $display("[TB] FAIL erase_reset_release: got %0d cycles want %0d", fall_at, RESET_HOLD); end
  endtask

  task automatic test_erase_abort();
    int wr_cnt = 0;
    logic [7:0] b;
    eject = 1'b1;
    for (int c = 0; c < 40 && wr_cnt < 5; c++) begin
      @(negedge clk_sys);
      eject = 1'b0;
      if (ram_we === 1'b1) wr_cnt++;
    end
    checks++;
    if (wr_cnt != 5) begin errors++; $display("[TB] FAIL abort_prewrites: got %0d want 5", wr_cnt); end
    ioctl_index = CART_IDX; ioctl_download = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (erasing !== 1'b0 || ram_we !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_stop: got erasing=%0b we=%0b want 0 and 0", erasing, ram_we);
    end
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = b;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 17'((CART_BASE + i) ^ 1) || ram_din !== b) begin
        errors++; $display("[TB] FAIL abort_dl_write[%0d]: got we=%0b addr=%h din=%h want we=1 addr=%h din=%h", i, ram_we, ram_addr, ram_din, (CART_BASE + i) ^ 1, b);
      end
      @(negedge clk_sys);
      checks++;
      if (ram_we !== 1'b0 || erasing !== 1'b0) begin
        errors++; $display("[TB] FAIL abort_idle[%0d]: got we=%0b erasing=%0b want 0 and 0", i, ram_we, erasing);
      end
    end
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (cart_size !== 17'd4) begin errors++; $display("[TB] FAIL abort_cart_size: got %h want 4", cart_size); end
  endtask

  task automatic test_reset_mid_download();
    int model = 0;
    logic [7:0] b;
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 3; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'hFF;
      @(negedge clk_sys);
    end
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (rom_hash !== 16'd3) begin errors++; $display("[TB] FAIL pre_reset_hash: got %h want 0003", rom_hash); end
    ioctl_wr = 1'b1; ioctl_addr = 25'd7; ioctl_dout = 8'hFF; RESET = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (out_vec !== RESET_VEC) begin errors++; $display("[TB] FAIL mid_reset_outputs: got %h want %h", out_vec, RESET_VEC); end
    RESET = 1'b0; ioctl_wr = 1'b0; ioctl_download = 1'b0;
    @(negedge clk_sys);
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      b = 8'($urandom);
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = b;
      model = model + (b & 8'h01);
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
    end
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (rom_hash !== 16'(model)) begin errors++; $display("[TB] FAIL post_reset_hash: got %h want %h", rom_hash, model); end
    checks++;
    if (system_type !== 2'(model_type(model)) || core_reset !== 1'b1) begin
      errors++; $display("[TB] FAIL post_reset_type: got type=%0d core_reset=%0b want type=%0d core_reset=1", system_type, core_reset, model_type(model));
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_rom_small();
    test_rom_variant();
    test_cart(12);
    test_cart(6);
    test_erase();
    test_erase_abort();
    test_reset_mid_download();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
